// File: rtl/sort_result_serializer.sv
// -----------------------------------------------------------------------------
// sort_result_serializer
//
// Purpose:
//   Consumer of the bitonic sorter output. Each sorted frame of DEPTH words
//   arrives as a one-cycle in_valid pulse. It is captured into a two-slot
//   frame buffer and streamed out one word per beat, smallest element first,
//   over a valid/ready interface with last/index sideband. The two slots let
//   the sorter fire back-to-back while the sink stalls. A frame that arrives
//   while both slots are occupied is dropped, and the sticky overflow flag is
//   set.
//
// Ports:
//   clk           system clock; all state updates on the rising edge
//   rst           asynchronous active-low reset; clears all state
//   in_valid      one-cycle pulse; in_data holds a complete sorted frame
//   in_data       sorted frame [0:DEPTH-1]; element 0 is the smallest
//   out_data      current element of the head frame (0 when idle)
//   out_valid     out_data is valid
//   out_ready     sink accepts the beat when out_valid & out_ready
//   out_last      current beat is element DEPTH-1 of its frame
//   out_idx       index of the current element within its frame
//   overflow      sticky; at least one frame was dropped
//   clr_overflow  synchronous clear of overflow (a same-cycle drop wins)
//   busy          at least one frame is buffered
// -----------------------------------------------------------------------------
module sort_result_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data [0:DEPTH-1],
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic                       busy
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned N_SLOTS = 2;

    // Frame storage; not reset, because contents are only observed while
    // count != 0.
    logic [WIDTH-1:0] slot_mem [0:N_SLOTS-1][0:DEPTH-1];

    // Registered state
    logic [CNT_W-1:0] count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [IDX_W-1:0] elem_idx;
    logic             overflow_q;

    // Next-state values
    logic [CNT_W-1:0] count_nxt;
    logic             wr_ptr_nxt;
    logic             rd_ptr_nxt;
    logic [IDX_W-1:0] elem_idx_nxt;
    logic             overflow_nxt;

    // Handshake and decision terms
    logic valid_int;
    logic last_int;
    logic beat;
    logic frame_done;
    logic accept;
    logic drop;

    // Output valid and last are decoded from registered state only, so there
    // is no combinational path from in_valid to the output side.
    assign valid_int  = (count != CNT_W'(0));
    assign last_int   = valid_int && (elem_idx == IDX_W'(DEPTH - 1));
    assign beat       = valid_int && out_ready;
    assign frame_done = beat && last_int;

    // A full buffer can still accept a frame on the cycle it frees a slot.
    // In that case wr_ptr == rd_ptr, so the new frame lands in the freed slot.
    assign accept = in_valid && ((count < CNT_W'(N_SLOTS)) || frame_done);
    assign drop   = in_valid && !accept;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            elem_idx   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count      <= count_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            elem_idx   <= elem_idx_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    // Frame capture into the slot selected by wr_ptr
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_mem[wr_ptr][i] <= in_data[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        count_nxt    = count;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        elem_idx_nxt = elem_idx;
        overflow_nxt = overflow_q;

        if (accept) begin
            wr_ptr_nxt = ~wr_ptr;
        end

        // Occupancy: a fill and a drain in the same cycle cancel out.
        if (accept && !frame_done) begin
            count_nxt = count + CNT_W'(1);
        end else if (frame_done && !accept) begin
            count_nxt = count - CNT_W'(1);
        end

        // Read side: step through the head frame; wrap to the next slot on last.
        if (frame_done) begin
            elem_idx_nxt = '0;
            rd_ptr_nxt   = ~rd_ptr;
        end else if (beat) begin
            elem_idx_nxt = elem_idx + IDX_W'(1);
        end

        // Sticky drop flag; a drop beats a same-cycle clear.
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (clr_overflow) begin
            overflow_nxt = 1'b0;
        end
    end

    // Output decode; out_data is forced to zero while idle, so that reset
    // leaves every output at 0 even though slot storage is not cleared.
    always_comb begin
        out_valid = valid_int;
        out_last  = last_int;
        out_idx   = elem_idx;
        out_data  = '0;
        if (valid_int) begin
            out_data = slot_mem[rd_ptr][elem_idx];
        end
        overflow  = overflow_q;
        busy      = valid_int;
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
module tb_sort_result_serializer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data [0:DEPTH-1];
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;
    logic             overflow;
    logic             clr_overflow;
    logic             busy;

    int errors = 0;
    int checks = 0;

    sort_result_serializer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_idx      (out_idx),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame with elements base, base+1, ... (ascending, as the sorter delivers).
    task automatic set_frame(input int base);
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data[i] = 32'(base + i);
        end
    endtask

    task automatic expect_beat(input string tag, input int data, input int idx, input bit last);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"},  out_data,        32'(data));
        chk({tag, " idx"},   32'(out_idx),   32'(idx));
        chk({tag, " last"},  32'(out_last),  32'(last));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        set_frame(0);

        // Reset state
        #2;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data",  out_data,        32'd0);
        chk("rst out_idx",   32'(out_idx),   32'd0);
        chk("rst out_last",  32'(out_last),  32'd0);
        chk("rst overflow",  32'(overflow),  32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        rst = 1'b1;

        // Single frame, sink always ready
        set_frame(1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("t1 beat%0d", i), i + 1, i, i == 7);
            tick();
        end
        expect_idle("t1 after");
        chk("t1 overflow", 32'(overflow), 32'd0);

        // Backpressure on cycles 3..5 holds element 3 at index 2
        set_frame(1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_beat($sformatf("t2 beat%0d", i), i + 1, i, 1'b0);
            tick();
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            expect_beat($sformatf("t2 stall%0d", s), 3, 2, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            expect_beat($sformatf("t2 beat%0d", i), i + 1, i, i == 7);
            tick();
        end
        expect_idle("t2 after");

        // Two frames back-to-back, no bubble between them
        set_frame(0);
        in_valid = 1'b1;
        tick();
        set_frame(10);
        for (int i = 0; i < 16; i++) begin
            expect_beat($sformatf("t3 beat%0d", i), (i < 8) ? i : 10 + i - 8, i % 8, (i % 8) == 7);
            tick();
            in_valid = 1'b0;
        end
        expect_idle("t3 after");

        // Overflow: third frame dropped while the sink stalls
        out_ready = 1'b0;
        set_frame(30);
        in_valid = 1'b1;
        tick();
        set_frame(40);
        tick();
        chk("t4 ovf before drop", 32'(overflow), 32'd0);
        chk("t4 busy full",       32'(busy),     32'd1);
        set_frame(50);
        tick();
        in_valid = 1'b0;
        chk("t4 ovf set", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_beat($sformatf("t4 beat%0d", i), (i < 8) ? 30 + i : 40 + i - 8, i % 8, (i % 8) == 7);
            tick();
        end
        expect_idle("t4 after");
        chk("t4 ovf sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4 ovf cleared", 32'(overflow), 32'd0);

        // Simultaneous free/accept with a full buffer
        out_ready = 1'b0;
        set_frame(60);
        in_valid = 1'b1;
        tick();
        set_frame(70);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("t5 A%0d", i), 60 + i, i, i == 7);
            if (i == 7) begin
                set_frame(80);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        chk("t5 ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            expect_beat($sformatf("t5 BC%0d", i), (i < 8) ? 70 + i : 80 + i - 8, i % 8, (i % 8) == 7);
            tick();
        end
        expect_idle("t5 after");
        chk("t5 ovf end", 32'(overflow), 32'd0);

        // Async reset mid-stream with a second frame buffered and overflow set
        set_frame(90);
        in_valid = 1'b1;
        tick();
        set_frame(100);
        expect_beat("t6 A0", 90, 0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            expect_beat($sformatf("t6 A%0d", i), 90 + i, i, 1'b0);
            tick();
        end
        out_ready = 1'b0;
        set_frame(110);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_beat("t6 A4 held", 94, 4, 1'b0);
        chk("t6 ovf before rst", 32'(overflow), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6 rst valid", 32'(out_valid), 32'd0);
        chk("t6 rst data",  out_data,        32'd0);
        chk("t6 rst idx",   32'(out_idx),   32'd0);
        chk("t6 rst last",  32'(out_last),  32'd0);
        chk("t6 rst busy",  32'(busy),      32'd0);
        chk("t6 rst ovf",   32'(overflow),  32'd0);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_idle($sformatf("t6 post%0d", c));
        end
        set_frame(9);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("t6 N%0d", i), 9 + i, i, i == 7);
            tick();
        end
        expect_idle("t6 end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
Name: sort_result_serializer

Overview:
- Downstream consumer of the bitonic sort top level.
- Captures each sorted frame of DEPTH words, presented as a one-cycle valid pulse, into a two-slot frame buffer.
- Streams the frame out one word per beat, smallest element first, over a valid/ready interface with last/index sideband.
- Absorbs back-to-back sorter output while the downstream sink stalls, and flags dropped frames.

Parameters:
WIDTH, 32, bit width of each element
DEPTH, 8, elements per frame (power of two, >=2)
IDX_W, $clog2(DEPTH), derived localparam: width of element index

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset; clears all state when low
in_valid  in  1  one-cycle pulse: in_data holds a complete sorted frame
in_data  in  DEPTH x WIDTH  sorted frame, unpacked [0:DEPTH-1], element 0 = smallest
out_data  out  WIDTH  current element of head frame
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts beat when out_valid & out_ready
out_last  out  1  current beat is element DEPTH-1 of its frame
out_idx  out  IDX_W  index of current element within frame
overflow  out  1  sticky: at least one frame dropped
clr_overflow  in  1  synchronous clear of overflow
busy  out  1  at least one frame buffered (count != 0)

Behaviour:
- Reset (rst low, async):
  - count=0, wr_ptr=0, rd_ptr=0, elem_idx=0, overflow=0.
  - All outputs 0 (out_data, out_valid, out_last, out_idx, busy).
  - Slot storage is not required to be cleared.
  - Reset mid-frame discards all buffered frames; no partial beats after release.
- Storage: two frame slots, each DEPTH x WIDTH. Counters are wr_ptr (1b), rd_ptr (1b), count (0..2), elem_idx (IDX_W).
- Beat handshake: beat = out_valid & out_ready.
- Frame completion: frame_done = beat & out_last.
- Accept rule: frame accepted when in_valid & (count<2 | frame_done).
  - On accept: slot[wr_ptr] <= in_data; wr_ptr toggles.
  - Accepting while count==2 and frame_done in the same cycle is legal. It writes into the slot being freed, which is slot[rd_ptr] == slot[wr_ptr].
- Drop rule: in_valid & count==2 & !frame_done means the frame is discarded, overflow <= 1, and buffer contents are untouched.
- count update:
  - +1 on accept without frame_done.
  - -1 on frame_done without accept.
  - Unchanged if both or neither.
- Output datapath:
  - out_valid = (count != 0), registered state only. No combinational path from in_valid to out_valid.
  - out_data = slot[rd_ptr][elem_idx].
  - out_idx = elem_idx.
  - out_last = out_valid & (elem_idx == DEPTH-1).
- Latency: frame pulsed at edge N (empty buffer) gives out_valid=1 with element 0 at N+1. With out_ready held high, the last element appears at N+DEPTH. Throughput is one element per cycle.
- Stall rule: while out_valid & !out_ready, out_data, out_idx, out_last and rd_ptr are held stable (AXI-stream style).
- Advance:
  - A beat with !out_last increments elem_idx.
  - frame_done sets elem_idx to 0 and toggles rd_ptr.
  - Back-to-back frames stream with no bubble.
- overflow:
  - Set on a drop.
  - Cleared by clr_overflow when no drop occurs in the same cycle. If both happen in the same cycle, set wins.
- busy = (count != 0).

Test Plan:
- Single frame, sink always ready: in_data={1,2,3,4,5,6,7,8}, DEPTH=8, pulse at cycle 0 -> out_valid cycles 1..8, out_data 1..8, out_idx 0..7, out_last only at cycle 8, busy deasserts cycle 9, overflow=0.
- Backpressure: out_ready low on cycles 3-5 of above -> out_data=3, out_idx=2 held stable through stall. Full sequence 1..8 delivered exactly once, last beat at cycle 11.
- Two frames back-to-back, sink ready: frame A={0..7} at cycle 0, frame B={10..17} at cycle 1 -> 16 consecutive beats 0..7 then 10..17, no bubble, out_last at beats 8 and 16.
- Overflow: out_ready=0, pulse frames A, B, C -> A and B retained, C dropped, overflow=1 from next cycle. Releasing ready yields A then B only. clr_overflow pulse -> overflow=0.
- Simultaneous free/accept: buffer full (count=2), frame C pulsed on the exact cycle A's last beat is accepted -> C accepted, no overflow, output sequence A, B, C.
- Async reset mid-stream: drop rst low at beat 4 of frame A with B buffered -> all outputs 0 immediately without a clock edge. After release, out_valid stays 0 until next in_valid; a new frame {9,..} streams from index 0.
